// File: rtl/charmap_pkg.sv
// Shared constants and helpers for the scrolling character-map renderer:
// BBGGGRRR colour fields, colour expansion and a constant log2.
package charmap_pkg;

    localparam logic [7:0] BG_KEY_DEF = 8'hC7;

    // BBGGGRRR field positions
    localparam int R_LSB = 0;
    localparam int R_MSB = 2;
    localparam int G_LSB = 3;
    localparam int G_MSB = 5;
    localparam int B_LSB = 6;
    localparam int B_MSB = 7;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] exp3(input logic [2:0] c);
        return {c, c, 2'b00};
    endfunction

    function automatic logic [7:0] exp2(input logic [1:0] c);
        return {c, c, c, 2'b00};
    endfunction

endpackage

// File: rtl/charmap_scroll_regs.sv
// Pending/live scroll registers; live only updates on a vblank rising edge
// so a frame is always drawn with one consistent scroll value.
module charmap_scroll_regs
    import charmap_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       vblank,
    input  logic [8:0] scroll_x,
    input  logic [8:0] scroll_y,
    input  logic       scroll_wr,
    output logic [8:0] live_x,
    output logic [8:0] live_y
);

    logic [8:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [8:0] live_x_q, live_x_d, live_y_q, live_y_d;
    logic       pending_q, pending_d;
    logic       vblank_q, vblank_d;
    logic       armed_q, armed_d;
    logic       vb_rise;

    // armed_q blocks a false edge when vblank is already high out of reset
    assign vb_rise = vblank & ~vblank_q & armed_q;

    always_comb begin
        pend_x_d  = pend_x_q;
        pend_y_d  = pend_y_q;
        live_x_d  = live_x_q;
        live_y_d  = live_y_q;
        pending_d = pending_q;
        vblank_d  = vblank;
        armed_d   = 1'b1;
        if (scroll_wr) begin
            pend_x_d = scroll_x;
            pend_y_d = scroll_y;
        end
        if (vb_rise) begin
            pending_d = 1'b0;
            if (scroll_wr) begin
                live_x_d = scroll_x;
                live_y_d = scroll_y;
            end else if (pending_q) begin
                live_x_d = pend_x_q;
                live_y_d = pend_y_q;
            end
        end else if (scroll_wr) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_x_q  <= '0;
            pend_y_q  <= '0;
            live_x_q  <= '0;
            live_y_q  <= '0;
            pending_q <= 1'b0;
            vblank_q  <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            pend_x_q  <= pend_x_d;
            pend_y_q  <= pend_y_d;
            live_x_q  <= live_x_d;
            live_y_q  <= live_y_d;
            pending_q <= pending_d;
            vblank_q  <= vblank_d;
            armed_q   <= armed_d;
        end
    end

    assign live_x = live_x_q;
    assign live_y = live_y_q;

endmodule

// File: rtl/charmap_scroll.sv
// Three-stage character-map renderer with vblank-latched scroll: chram
// address, chrom address, then colour select; pixel out 3 cycles after raster.
module charmap_scroll
    import charmap_pkg::*;
#(
    parameter int         COLS       = 64,
    parameter int         ROWS       = 64,
    parameter int         GLYPH_BITS = 8,
    parameter int         ROM_AW     = 12,
    parameter logic [7:0] BG_KEY     = BG_KEY_DEF
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [8:0]                            hcnt,
    input  logic [8:0]                            vcnt,
    input  logic                                  pix_en,
    input  logic                                  vblank,
    input  logic [8:0]                            scroll_x,
    input  logic [8:0]                            scroll_y,
    input  logic                                  scroll_wr,
    input  logic [GLYPH_BITS-1:0]                 chmap_data_out,
    input  logic [7:0]                            fgcolram_data_out,
    input  logic [7:0]                            bgcolram_data_out,
    input  logic [7:0]                            chrom_data_out,
    output logic [clog2(ROWS)+clog2(COLS)-1:0]    chram_addr,
    output logic [ROM_AW-1:0]                     chrom_addr,
    output logic [7:0]                            r,
    output logic [7:0]                            g,
    output logic [7:0]                            b,
    output logic                                  a,
    output logic                                  pix_valid
);

    localparam int LC  = clog2(COLS);
    localparam int LR  = clog2(ROWS);
    localparam int CW  = LC + 3;
    localparam int RW  = LR + 3;
    localparam int CAW = LC + LR;

    logic [8:0] live_x, live_y;

    charmap_scroll_regs u_regs (
        .clk       (clk),
        .reset     (reset),
        .vblank    (vblank),
        .scroll_x  (scroll_x),
        .scroll_y  (scroll_y),
        .scroll_wr (scroll_wr),
        .live_x    (live_x),
        .live_y    (live_y)
    );

    logic [8:0]    sum_x, sum_y;
    logic [CW-1:0] ex;
    logic [RW-1:0] ey;
    logic          unused_hi;

    // Truncation to the map width in pixels is the wrap-around
    assign sum_x     = hcnt + live_x;
    assign sum_y     = vcnt + live_y;
    assign ex        = sum_x[CW-1:0];
    assign ey        = sum_y[RW-1:0];
    assign unused_hi = ^{sum_x, sum_y};

    logic [2:0]        vld_pipe_q, vld_pipe_d;
    logic [CAW-1:0]    chram_addr_q, chram_addr_d;
    logic [2:0]        px0_q, px0_d, gy0_q, gy0_d;
    logic [ROM_AW-1:0] chrom_addr_q, chrom_addr_d;
    logic [2:0]        px1_q, px1_d;
    logic [7:0]        fg1_q, fg1_d, bg1_q, bg1_d;
    logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;
    logic              a_q, a_d;
    logic              pbit;
    logic [7:0]        col;

    always_comb begin
        vld_pipe_d   = {vld_pipe_q[1:0], pix_en};
        chram_addr_d = {ey[RW-1:3], ex[CW-1:3]};
        px0_d        = ex[2:0];
        gy0_d        = ey[2:0];
        chrom_addr_d = ROM_AW'({chmap_data_out, gy0_q});
        px1_d        = px0_q;
        fg1_d        = fgcolram_data_out;
        bg1_d        = bgcolram_data_out;
        // bit 7 is the leftmost pixel, so index 7-px, i.e. ~px
        pbit         = chrom_data_out[~px1_q];
        col          = pbit ? fg1_q : bg1_q;
        r_d          = '0;
        g_d          = '0;
        b_d          = '0;
        a_d          = 1'b0;
        if (vld_pipe_q[1]) begin
            r_d = exp3(col[R_MSB:R_LSB]);
            g_d = exp3(col[G_MSB:G_LSB]);
            b_d = exp2(col[B_MSB:B_LSB]);
            a_d = pbit | (bg1_q != BG_KEY);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe_q   <= '0;
            chram_addr_q <= '0;
            px0_q        <= '0;
            gy0_q        <= '0;
            chrom_addr_q <= '0;
            px1_q        <= '0;
            fg1_q        <= '0;
            bg1_q        <= '0;
            r_q          <= '0;
            g_q          <= '0;
            b_q          <= '0;
            a_q          <= 1'b0;
        end else begin
            vld_pipe_q   <= vld_pipe_d;
            chram_addr_q <= chram_addr_d;
            px0_q        <= px0_d;
            gy0_q        <= gy0_d;
            chrom_addr_q <= chrom_addr_d;
            px1_q        <= px1_d;
            fg1_q        <= fg1_d;
            bg1_q        <= bg1_d;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
            a_q          <= a_d;
        end
    end

    assign chram_addr = chram_addr_q;
    assign chrom_addr = chrom_addr_q;
    assign r          = r_q;
    assign g          = g_q;
    assign b          = b_q;
    assign a          = a_q;
    assign pix_valid  = vld_pipe_q[2];

endmodule

// File: tb/tb_charmap_scroll.sv
// Directed bench: default-size renderer against combinational memory models
// on the registered addresses, plus a reduced-size instance (32x16, 9-bit codes).
module tb_charmap_scroll;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] hcnt, vcnt, scroll_x, scroll_y;
    logic       pix_en, vblank, scroll_wr;

    logic [7:0]  chmap_data, fg_data, bg_data, rom_data;
    logic [11:0] chram_addr, chrom_addr;
    logic [7:0]  r, g, b;
    logic        a, pix_valid;

    logic [7:0] cmap [0:4095];
    logic [7:0] fgm  [0:4095];
    logic [7:0] bgm  [0:4095];
    logic [7:0] rom  [0:4095];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign chmap_data = cmap[chram_addr];
    assign fg_data    = fgm[chram_addr];
    assign bg_data    = bgm[chram_addr];
    assign rom_data   = rom[chrom_addr];

    charmap_scroll dut (
        .clk(clk), .reset(reset), .hcnt(hcnt), .vcnt(vcnt), .pix_en(pix_en),
        .vblank(vblank), .scroll_x(scroll_x), .scroll_y(scroll_y),
        .scroll_wr(scroll_wr), .chmap_data_out(chmap_data),
        .fgcolram_data_out(fg_data), .bgcolram_data_out(bg_data),
        .chrom_data_out(rom_data), .chram_addr(chram_addr),
        .chrom_addr(chrom_addr), .r(r), .g(g), .b(b), .a(a),
        .pix_valid(pix_valid)
    );

    logic [8:0]  chram_addr2;
    logic [11:0] chrom_addr2;
    logic [7:0]  r2, g2, b2;
    logic        a2, pv2;

    charmap_scroll #(.COLS(32), .ROWS(16), .GLYPH_BITS(9)) dut2 (
        .clk(clk), .reset(reset), .hcnt(9'd8), .vcnt(9'd13), .pix_en(1'b1),
        .vblank(1'b0), .scroll_x(9'd0), .scroll_y(9'd0), .scroll_wr(1'b0),
        .chmap_data_out(9'h1FF), .fgcolram_data_out(8'h00),
        .bgcolram_data_out(8'h00), .chrom_data_out(8'h00),
        .chram_addr(chram_addr2), .chrom_addr(chrom_addr2),
        .r(r2), .g(g2), .b(b2), .a(a2), .pix_valid(pv2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One pixel through the pipe: addresses at N+1/N+2, colour at N+3
    task automatic pix(input string tag, input logic [8:0] h, input logic [8:0] v,
                       input logic [11:0] e_cram, input logic [11:0] e_crom,
                       input logic [7:0] er, input logic [7:0] eg,
                       input logic [7:0] eb, input logic ea);
        hcnt = h; vcnt = v; pix_en = 1'b1;
        step();
        chk({tag, ".chram"}, 32'(chram_addr), 32'(e_cram));
        pix_en = 1'b0;
        step();
        chk({tag, ".chrom"}, 32'(chrom_addr), 32'(e_crom));
        step();
        chk({tag, ".rgb"}, {8'h0, r, g, b}, {8'h0, er, eg, eb});
        chk({tag, ".a"}, 32'(a), 32'(ea));
        chk({tag, ".pv"}, 32'(pix_valid), 32'd1);
        step();
        chk({tag, ".pv_off"}, 32'(pix_valid), 32'd0);
    endtask

    task automatic vb_pulse();
        vblank = 1'b1; step();
        vblank = 1'b0; step();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            cmap[i] = '0; fgm[i] = '0; bgm[i] = '0; rom[i] = '0;
        end
        reset = 1'b1; hcnt = '0; vcnt = '0; pix_en = 1'b0; vblank = 1'b0;
        scroll_x = '0; scroll_y = '0; scroll_wr = 1'b0;
        repeat (3) step();
        chk("rst.addr", {8'h0, chram_addr, chrom_addr}, 32'h0);
        chk("rst.pix", {6'h0, r, g, b, a, pix_valid}, 32'h0);
        reset = 1'b0;

        cmap[1] = 8'h41; fgm[1] = 8'h07; bgm[1] = 8'h00; rom[12'h208] = 8'h80;
        pix("A", 9'd8, 9'd0, 12'h001, 12'h208, 8'hFC, 8'h00, 8'h00, 1'b1);

        bgm[1] = 8'hC7;
        pix("B_key", 9'd9, 9'd0, 12'h001, 12'h208, 8'hFC, 8'h00, 8'hFC, 1'b0);
        bgm[1] = 8'h38;
        pix("B_grn", 9'd9, 9'd0, 12'h001, 12'h208, 8'h00, 8'hFC, 8'h00, 1'b1);

        scroll_x = 9'd504; scroll_wr = 1'b1; step(); scroll_wr = 1'b0;
        vb_pulse();
        pix("wrap", 9'd16, 9'd0, 12'h001, 12'h208, 8'hFC, 8'h00, 8'h00, 1'b1);

        scroll_x = 9'd0; scroll_wr = 1'b1; step(); scroll_wr = 1'b0;
        pix("mid", 9'd16, 9'd0, 12'h001, 12'h208, 8'hFC, 8'h00, 8'h00, 1'b1);
        vb_pulse();
        pix("next", 9'd16, 9'd0, 12'h002, 12'h000, 8'h00, 8'h00, 8'h00, 1'b1);

        scroll_x = 9'd8; scroll_y = 9'd4; scroll_wr = 1'b1; vblank = 1'b1; step();
        scroll_wr = 1'b0; vblank = 1'b0; step();
        pix("edge_wr", 9'd0, 9'd0, 12'h001, 12'h20C, 8'h00, 8'hFC, 8'h00, 1'b1);
        vb_pulse();
        pix("edge_hold", 9'd0, 9'd0, 12'h001, 12'h20C, 8'h00, 8'hFC, 8'h00, 1'b1);

        hcnt = 9'd8; vcnt = 9'd0; pix_en = 1'b1;
        repeat (3) step();
        chk("stream.pv", 32'(pix_valid), 32'd1);
        reset = 1'b1; step();
        chk("rst_mid.pix", {6'h0, r, g, b, a, pix_valid}, 32'h0);
        chk("rst_mid.addr", {8'h0, chram_addr, chrom_addr}, 32'h0);
        reset = 1'b0; step();
        chk("rel.c1", 32'(pix_valid), 32'd0);
        step();
        chk("rel.c2", 32'(pix_valid), 32'd0);
        step();
        chk("rel.c3", 32'(pix_valid), 32'd1);
        chk("rel.r", 32'(r), 32'hFC);
        pix_en = 1'b0;

        chk("sweep.chram", 32'(chram_addr2), 32'h021);
        chk("sweep.chrom", 32'(chrom_addr2), 32'hFFD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
